// File: rtl/data_readout_framer_if.sv
// ----------------------------------------------------------------------------
// data_readout_framer_if
//
// Purpose: bundles the two byte handshakes around the readout framer.
//   Storage side (byte FIFO):  data_ready_to_send, data_in, data_valid, read_enable
//   Transmit side (UART TX):   tx_data, tx_start, tx_busy
//
// Modports:
//   master - the framer: consumes storage bytes, drives the transmitter
//   slave  - the environment: storage FIFO and UART transmitter
// ----------------------------------------------------------------------------
interface data_readout_framer_if;
    logic       data_ready_to_send;  // storage FIFO non-empty
    logic [7:0] data_in;             // storage byte output
    logic       data_valid;          // data_in valid this cycle
    logic       read_enable;         // one-cycle read request to storage
    logic [7:0] tx_data;             // byte to the transmitter
    logic       tx_start;            // one-cycle start pulse, tx_data valid with it
    logic       tx_busy;             // transmitter is shifting a byte

    modport master (
        input  data_ready_to_send,
        input  data_in,
        input  data_valid,
        input  tx_busy,
        output read_enable,
        output tx_data,
        output tx_start
    );

    modport slave (
        output data_ready_to_send,
        output data_in,
        output data_valid,
        output tx_busy,
        input  read_enable,
        input  tx_data,
        input  tx_start
    );
endinterface

// File: rtl/data_readout_framer.sv
// ----------------------------------------------------------------------------
// data_readout_framer
//
// Purpose: pulls sample bytes from the storage byte FIFO and sends them to the
// UART transmitter wrapped in a frame:
//   HEADER_BYTE, payload (1..MAX_PAYLOAD bytes or empty), count[15:8],
//   count[7:0], and optionally a checksum byte making payload+checksum == 0
//   mod 256.
//
// Build option: define READOUT_CHECKSUM_EN to append the checksum byte.
// Without it there is no SUM state and no running-sum register.
//
// Parameters:
//   HEADER_BYTE   - first byte of every frame
//   MAX_PAYLOAD   - payload bytes per frame, 1..65535
//   VALID_TIMEOUT - cycles to wait for data_valid after a read request (>= 1)
//
// Ports:
//   i_clock        - single clock
//   i_reset        - synchronous, active-high reset
//   i_enable       - permits new frames, sampled only in IDLE
//   io_bus         - storage and transmitter handshakes (master modport)
//   o_busy         - high in every state except IDLE
//   o_timeout      - sticky: a read request got no data_valid; cleared at header
//   o_frame_count  - completed frames, wraps at 16 bits
// All outputs are registered.
// ----------------------------------------------------------------------------
module data_readout_framer #(
    parameter logic [7:0]  HEADER_BYTE   = 8'hA5,
    parameter int unsigned MAX_PAYLOAD   = 1024,
    parameter int unsigned VALID_TIMEOUT = 4
) (
    input  logic                         i_clock,
    input  logic                         i_reset,
    input  logic                         i_enable,
    data_readout_framer_if.master        io_bus,
    output logic                         o_busy,
    output logic                         o_timeout,
    output logic [15:0]                  o_frame_count
);

    localparam logic [15:0] LP_MAX_PAYLOAD   = 16'(MAX_PAYLOAD);
    localparam logic [15:0] LP_VALID_TIMEOUT = 16'(VALID_TIMEOUT);

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_HDR    = 4'd1,
        ST_REQ    = 4'd2,
        ST_WAITV  = 4'd3,
        ST_PAY    = 4'd4,
        ST_LENH   = 4'd5,
        ST_LENL   = 4'd6,
`ifdef READOUT_CHECKSUM_EN
        ST_SUM    = 4'd7,
`endif
        ST_TXWAIT = 4'd8
    } state_t;

`ifdef READOUT_CHECKSUM_EN
    // Byte that brings the payload sum to zero mod 256.
    function automatic logic [7:0] f_checksum(input logic [7:0] sum);
        return 8'd0 - sum;
    endfunction
`endif

    state_t      r_state;
    state_t      r_ret_state;      // where TXWAIT returns once the byte is gone
    state_t      w_state_nxt;
    state_t      w_ret_nxt;

    logic        r_txw_first;      // first TXWAIT cycle: tx_busy not yet meaningful
    logic [15:0] r_timer;          // cycles spent in WAITV
    logic [15:0] r_count;          // payload bytes in the current frame
    logic [7:0]  r_byte;           // captured payload byte awaiting PAY
`ifdef READOUT_CHECKSUM_EN
    logic [7:0]  r_sum;            // running payload sum mod 256
`endif

    logic        r_read_enable;
    logic        r_tx_start;
    logic [7:0]  r_tx_data;
    logic        r_busy;
    logic        r_timeout;
    logic [15:0] r_frame_count;

    logic        w_read_enable_nxt;
    logic        w_tx_start_nxt;
    logic [7:0]  w_tx_data_nxt;

    logic        w_read_ok;
    logic        w_in_window;
    logic        w_capture;
    logic        w_expire;
    logic        w_txw_leave;
    logic        w_frame_done;

    // The read lands one cycle after the request, so the WAITV cycle holding
    // the visible read_enable (timer 0) is outside the acceptance window.
    assign w_read_ok    = io_bus.data_ready_to_send && (r_count < LP_MAX_PAYLOAD);
    assign w_in_window  = (r_state == ST_WAITV) && (r_timer != 16'd0);
    assign w_capture    = w_in_window && io_bus.data_valid;
    assign w_expire     = (r_state == ST_WAITV) && !w_capture && (r_timer >= LP_VALID_TIMEOUT);
    assign w_txw_leave  = (r_state == ST_TXWAIT) && !r_txw_first && !io_bus.tx_busy;
    assign w_frame_done = w_txw_leave && (r_ret_state == ST_IDLE);

    assign io_bus.read_enable = r_read_enable;
    assign io_bus.tx_start    = r_tx_start;
    assign io_bus.tx_data     = r_tx_data;
    assign o_busy             = r_busy;
    assign o_timeout          = r_timeout;
    assign o_frame_count      = r_frame_count;

    // State and return-state registers.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_ret_state <= ST_IDLE;
        end else begin
            r_state     <= w_state_nxt;
            r_ret_state <= w_ret_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        w_ret_nxt   = r_ret_state;
        case (r_state)
            ST_IDLE: begin
                if (i_enable && io_bus.data_ready_to_send) begin
                    w_state_nxt = ST_HDR;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_HDR: begin
                w_state_nxt = ST_TXWAIT;
                w_ret_nxt   = ST_REQ;
            end
            ST_REQ: begin
                if (w_read_ok) begin
                    w_state_nxt = ST_WAITV;
                end else begin
                    w_state_nxt = ST_LENH;
                end
            end
            ST_WAITV: begin
                if (w_capture) begin
                    w_state_nxt = ST_PAY;
                end else if (w_expire) begin
                    w_state_nxt = ST_LENH;
                end else begin
                    w_state_nxt = ST_WAITV;
                end
            end
            ST_PAY: begin
                w_state_nxt = ST_TXWAIT;
                w_ret_nxt   = ST_REQ;
            end
            ST_LENH: begin
                w_state_nxt = ST_TXWAIT;
                w_ret_nxt   = ST_LENL;
            end
            ST_LENL: begin
                w_state_nxt = ST_TXWAIT;
`ifdef READOUT_CHECKSUM_EN
                w_ret_nxt   = ST_SUM;
`else
                w_ret_nxt   = ST_IDLE;
`endif
            end
`ifdef READOUT_CHECKSUM_EN
            ST_SUM: begin
                w_state_nxt = ST_TXWAIT;
                w_ret_nxt   = ST_IDLE;
            end
`endif
            ST_TXWAIT: begin
                if (w_txw_leave) begin
                    w_state_nxt = r_ret_state;
                end else begin
                    w_state_nxt = ST_TXWAIT;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_ret_nxt   = ST_IDLE;
            end
        endcase
    end

    // Output decode: next values of the registered handshake outputs.
    always_comb begin
        w_read_enable_nxt = 1'b0;
        w_tx_start_nxt    = 1'b0;
        w_tx_data_nxt     = r_tx_data;
        case (r_state)
            ST_HDR: begin
                w_tx_start_nxt = 1'b1;
                w_tx_data_nxt  = HEADER_BYTE;
            end
            ST_REQ: begin
                w_read_enable_nxt = w_read_ok;
            end
            ST_PAY: begin
                w_tx_start_nxt = 1'b1;
                w_tx_data_nxt  = r_byte;
            end
            ST_LENH: begin
                w_tx_start_nxt = 1'b1;
                w_tx_data_nxt  = r_count[15:8];
            end
            ST_LENL: begin
                w_tx_start_nxt = 1'b1;
                w_tx_data_nxt  = r_count[7:0];
            end
`ifdef READOUT_CHECKSUM_EN
            ST_SUM: begin
                w_tx_start_nxt = 1'b1;
                w_tx_data_nxt  = f_checksum(r_sum);
            end
`endif
            default: begin
                w_read_enable_nxt = 1'b0;
                w_tx_start_nxt    = 1'b0;
                w_tx_data_nxt     = r_tx_data;
            end
        endcase
    end

    // Registered outputs; every start is followed by TXWAIT, so the start
    // pulse also marks TXWAIT's mandatory first cycle.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_read_enable <= 1'b0;
            r_tx_start    <= 1'b0;
            r_tx_data     <= 8'h00;
            r_busy        <= 1'b0;
            r_txw_first   <= 1'b0;
        end else begin
            r_read_enable <= w_read_enable_nxt;
            r_tx_start    <= w_tx_start_nxt;
            r_tx_data     <= w_tx_data_nxt;
            r_busy        <= (w_state_nxt != ST_IDLE);
            r_txw_first   <= w_tx_start_nxt;
        end
    end

    // Payload datapath, timeout flag and frame counter.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_timer       <= 16'd0;
            r_count       <= 16'd0;
            r_byte        <= 8'h00;
            r_timeout     <= 1'b0;
            r_frame_count <= 16'd0;
        end else begin
            if (r_state == ST_WAITV) begin
                r_timer <= r_timer + 16'd1;
            end else begin
                r_timer <= 16'd0;
            end

            if (r_state == ST_HDR) begin
                r_count   <= 16'd0;
                r_timeout <= 1'b0;
            end else if (w_capture) begin
                r_count   <= r_count + 16'd1;
                r_byte    <= io_bus.data_in;
            end else if (w_expire) begin
                r_timeout <= 1'b1;
            end

            if (w_frame_done) begin
                r_frame_count <= r_frame_count + 16'd1;
            end
        end
    end

`ifdef READOUT_CHECKSUM_EN
    // Running payload sum for the checksum byte.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_sum <= 8'h00;
        end else if (r_state == ST_HDR) begin
            r_sum <= 8'h00;
        end else if (w_capture) begin
            r_sum <= r_sum + io_bus.data_in;
        end
    end
`endif

endmodule

// File: tb/tb_data_readout_framer.sv
module tb_data_readout_framer;

    localparam int MAXP = 4;
    localparam int VTO  = 4;
`ifdef READOUT_CHECKSUM_EN
    localparam int FRAME_OVH = 4;
`else
    localparam int FRAME_OVH = 3;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        o_busy;
    logic        o_timeout;
    logic [15:0] fc;

    data_readout_framer_if bus_if();

    data_readout_framer #(
        .HEADER_BYTE   (8'hA5),
        .MAX_PAYLOAD   (MAXP),
        .VALID_TIMEOUT (VTO)
    ) dut (
        .i_clock       (clk),
        .i_reset       (rst),
        .i_enable      (en),
        .io_bus        (bus_if),
        .o_busy        (o_busy),
        .o_timeout     (o_timeout),
        .o_frame_count (fc)
    );

    always #5 clk = ~clk;

    // stimulus-owned environment settings
    logic [7:0] src_mem [0:15];
    int         src_len     = 0;
    bit         force_ready = 1'b0;
    bit         hold_valid  = 1'b0;
    int         busy_len    = 0;

    // model-owned state
    int         src_idx   = 0;
    logic [7:0] cap_mem [0:63];
    int         cap_n     = 0;
    int         rd_count  = 0;
    int         re_viol   = 0;
    int         tx_viol   = 0;
    int         busy_left = 0;
    bit         pend      = 1'b0;
    bit         prev_re   = 1'b0;
    logic [7:0] pend_byte = 8'h00;

    int         n_vec  = 0;
    int         n_miss = 0;
    logic [7:0] exp_q[$];
    logic [7:0] stim_q[$];

    // Storage FIFO (1-cycle read latency) and UART transmitter models, on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            pend              = 1'b0;
            prev_re           = 1'b0;
            busy_left         = 0;
            src_idx           = 0;
            cap_n             = 0;
            rd_count          = 0;
            bus_if.tx_busy    = 1'b0;
            bus_if.data_valid = 1'b0;
            bus_if.data_in    = 8'h00;
        end else begin
            if (bus_if.read_enable) begin
                rd_count = rd_count + 1;
                if (prev_re) re_viol = re_viol + 1;
            end
            prev_re = bus_if.read_enable;
            bus_if.data_valid = 1'b0;
            if (pend) begin
                if (!hold_valid) begin
                    bus_if.data_valid = 1'b1;
                    bus_if.data_in    = pend_byte;
                end
                pend = 1'b0;
            end
            if (bus_if.read_enable) begin
                pend = 1'b1;
                if (src_idx < src_len) begin
                    pend_byte = src_mem[src_idx];
                    src_idx   = src_idx + 1;
                end else begin
                    pend_byte = 8'hEE;
                end
            end
            if (bus_if.tx_start && cap_n < 64) begin
                cap_mem[cap_n] = bus_if.tx_data;
                cap_n = cap_n + 1;
            end
            bus_if.tx_busy = (busy_left > 0);
            if (busy_left > 0) busy_left = busy_left - 1;
            if (bus_if.tx_start && bus_if.tx_busy) tx_viol = tx_viol + 1;
            if (bus_if.tx_start) busy_left = busy_len;
        end
        bus_if.data_ready_to_send = force_ready || (src_idx < src_len);
    end

    task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_miss = n_miss + 1;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_value({tag, "_re"},      32'(bus_if.read_enable), 32'd0);
        check_value({tag, "_start"},   32'(bus_if.tx_start),    32'd0);
        check_value({tag, "_txdata"},  32'(bus_if.tx_data),     32'h00);
        check_value({tag, "_busy"},    32'(o_busy),             32'd0);
        check_value({tag, "_timeout"}, 32'(o_timeout),          32'd0);
        check_value({tag, "_fc"},      32'(fc),                 32'd0);
    endtask

    task automatic check_bytes(input string tag);
        check_value({tag, "_len"}, cap_n, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            check_value($sformatf("%s_b%0d", tag, i), 32'(cap_mem[i]), 32'(exp_q[i]));
        end
    endtask

    // Reset the DUT and the models, leaving stim_q as the storage contents.
    task automatic reset_and_load();
        @(posedge clk); #2;
        rst = 1'b1;
        en  = 1'b0;
        for (int i = 0; i < stim_q.size(); i++) src_mem[i] = stim_q[i];
        src_len = stim_q.size();
        @(posedge clk); #2;
        @(posedge clk); #2;
        rst = 1'b0;
    endtask

    task automatic run_until(input string tag, input int frames, input int budget);
        bit done = 1'b0;
        en = 1'b1;
        for (int i = 0; i < budget && !done; i++) begin
            @(posedge clk); #2;
            if (fc == 16'(frames) && !o_busy) done = 1'b1;
        end
        en = 1'b0;
        check_value({tag, "_done"}, 32'(done), 32'd1);
    endtask

    initial begin
        int  t_re;
        int  t_to;
        int  cyc;
        bit  seen;
        rst = 1'b1;
        en  = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_reset_outputs("por");
        rst = 1'b0;

        // Three bytes, idle transmitter.
        stim_q = '{8'h10, 8'h20, 8'h30};
        reset_and_load();
        run_until("t1", 1, 400);
        exp_q = '{8'hA5, 8'h10, 8'h20, 8'h30, 8'h00, 8'h03};
`ifdef READOUT_CHECKSUM_EN
        exp_q.push_back(8'hA0);
`endif
        check_bytes("t1");
        check_value("t1_fc", 32'(fc), 32'd1);
        check_value("t1_timeout", 32'(o_timeout), 32'd0);

        // Six bytes with MAX_PAYLOAD=4: two frames back to back.
        stim_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        reset_and_load();
        run_until("t2", 2, 800);
        exp_q = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h04};
`ifdef READOUT_CHECKSUM_EN
        exp_q.push_back(8'hF6);
`endif
        exp_q.push_back(8'hA5); exp_q.push_back(8'h05); exp_q.push_back(8'h06);
        exp_q.push_back(8'h00); exp_q.push_back(8'h02);
`ifdef READOUT_CHECKSUM_EN
        exp_q.push_back(8'hF5);
`endif
        check_bytes("t2");
        check_value("t2_fc", 32'(fc), 32'd2);

        // Ready but data_valid withheld: single read, timeout, empty frame.
        stim_q = {};
        force_ready = 1'b1;
        hold_valid  = 1'b1;
        reset_and_load();
        en = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk); #2;
            if (o_busy) seen = 1'b1;
        end
        en = 1'b0;
        check_value("t3_start", 32'(seen), 32'd1);
        t_re = -1; t_to = -1; cyc = 0; seen = 1'b0;
        for (int i = 0; i < 600 && !seen; i++) begin
            @(posedge clk); #2;
            cyc = cyc + 1;
            if (bus_if.read_enable && t_re < 0) t_re = cyc;
            if (o_timeout && t_to < 0) t_to = cyc;
            if (fc == 16'd1 && !o_busy) seen = 1'b1;
        end
        check_value("t3_done", 32'(seen), 32'd1);
        check_value("t3_reads", rd_count, 32'd1);
        check_value("t3_timeout", 32'(o_timeout), 32'd1);
        check_value("t3_to_delay", 32'(t_to - t_re), 32'(VTO + 1));
        exp_q = '{8'hA5, 8'h00, 8'h00};
`ifdef READOUT_CHECKSUM_EN
        exp_q.push_back(8'h00);
`endif
        check_bytes("t3");
        force_ready = 1'b0;
        hold_valid  = 1'b0;

        // Slow transmitter: busy 20 cycles after each start.
        stim_q = '{8'h10, 8'h20, 8'h30};
        busy_len = 20;
        reset_and_load();
        run_until("t4", 1, 3000);
        exp_q = '{8'hA5, 8'h10, 8'h20, 8'h30, 8'h00, 8'h03};
`ifdef READOUT_CHECKSUM_EN
        exp_q.push_back(8'hA0);
`endif
        check_bytes("t4");
        busy_len = 0;

        // Reset during the payload of frame 2.
        stim_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        reset_and_load();
        en = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 600 && !seen; i++) begin
            @(posedge clk); #2;
            if (cap_n >= MAXP + FRAME_OVH + 2) seen = 1'b1;
        end
        check_value("t5_in_frame2", 32'(seen), 32'd1);
        check_value("t5_fc_before", 32'(fc), 32'd1);
        rst = 1'b1;
        en  = 1'b0;
        @(posedge clk); #2;
        check_reset_outputs("t5_rst");
        stim_q = '{8'h77};
        for (int i = 0; i < stim_q.size(); i++) src_mem[i] = stim_q[i];
        src_len = stim_q.size();
        @(posedge clk); #2;
        rst = 1'b0;
        run_until("t5", 1, 400);
        exp_q = '{8'hA5, 8'h77, 8'h00, 8'h01};
`ifdef READOUT_CHECKSUM_EN
        exp_q.push_back(8'h89);
`endif
        check_bytes("t5");

        check_value("tx_start_while_busy", tx_viol, 32'd0);
        check_value("re_back_to_back", re_viol, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
